spi_ram_master: RTL and testbench

- Host-side SPI master that sits directly upstream of the SPI single-port-RAM wrapper (MOSI/MISO/SS_n slave).
- Converts one parallel host request (2-bit command + 8-bit payload) into a serial SS_n/MOSI frame clocked on the shared system clock.
- For read-data commands it captures the 8-bit MISO reply and returns it on a parallel bus.
- No separate SPI clock: the slave samples MOSI on clk, and the master launches one bit per clk.

---
 rtl/spi_ram_master_if.sv | 35 +++
 rtl/spi_ram_master.sv | 154 +++++++++++++++
 tb/tb_spi_ram_master.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_ram_master_if.sv
// Host/slave signal bundle for spi_ram_master.
// With SPI_RAM_MASTER_ERR_EN defined, err and err_sticky are also carried.
interface spi_ram_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       MOSI;
  logic       MISO;
  logic       SS_n;
`ifdef SPI_RAM_MASTER_ERR_EN
  logic       err;
  logic       err_sticky;
`endif

  // Seen from the master: host request and MISO in, everything else out.
  modport master (
    input  start, cmd, wr_data, MISO,
`ifdef SPI_RAM_MASTER_ERR_EN
    output err, err_sticky,
`endif
    output busy, done, rd_data, MOSI, SS_n
  );

  // Seen from the other side: host and SPI slave together.
  modport slave (
    output start, cmd, wr_data, MISO,
`ifdef SPI_RAM_MASTER_ERR_EN
    input  err, err_sticky,
`endif
    input  busy, done, rd_data, MOSI, SS_n
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI master feeding the SPI single-port-RAM wrapper on the shared clock.
// Frame: LEAD idle-low cycles, 11 bits {cmd[1],cmd[1],cmd[0],payload} MSB
// first, and for cmd=11 a RD_LATENCY wait plus 8 MISO samples, then GAP
// cycles with SS_n high.
// Optional macro SPI_RAM_MASTER_ERR_EN adds err / err_sticky for starts
// dropped while busy.
module spi_ram_master #(
  parameter int LEAD       = 1,
  parameter int RD_LATENCY = 2,
  parameter int GAP        = 1
) (
  input  logic              clk,
  input  logic              rst,
  spi_ram_master_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_SHIFT, S_WAIT_RD, S_RECV, S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] frame_q, frame_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        gap_last;
  logic        accept;

  // busy falls on the edge that ends the last gap cycle; a start sampled on
  // that same edge is taken, so back-to-back frames are exactly GAP apart.
  assign gap_last = (state_q == S_GAP) && (cnt_q == 4'(GAP - 1));
  assign accept   = bus.start && ((state_q == S_IDLE) || gap_last);

  // Next-state, counter, shift registers and next-cycle output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 4'd1;
    frame_d   = frame_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
      end
      S_LEAD: begin
        if (cnt_q == 4'(LEAD - 1)) begin
          state_d = S_SHIFT;
          cnt_d   = 4'd0;
        end
      end
      S_SHIFT: begin
        if (cnt_q == 4'd10) begin
          cnt_d   = 4'd0;
          state_d = (frame_q[9:8] == 2'b11) ? S_WAIT_RD : S_GAP;
        end
      end
      S_WAIT_RD: begin
        if (cnt_q == 4'(RD_LATENCY - 1)) begin
          state_d = S_RECV;
          cnt_d   = 4'd0;
        end
      end
      S_RECV: begin
        rx_d = {rx_q[6:0], bus.MISO};
        if (cnt_q == 4'd7) begin
          rd_data_d = rx_d;
          state_d   = S_GAP;
          cnt_d     = 4'd0;
        end
      end
      S_GAP: begin
        if (gap_last) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // A new request overrides the idle/gap decision; read data payload is all ones.
    if (accept) begin
      state_d = S_LEAD;
      cnt_d   = 4'd0;
      frame_d = {bus.cmd[1], bus.cmd, (bus.cmd == 2'b11) ? 8'hFF : bus.wr_data};
    end
    ss_n_d = (state_d == S_IDLE) || (state_d == S_GAP);
    mosi_d = (state_d == S_SHIFT) ? frame_d[4'd10 - cnt_d] : 1'b0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_GAP) && (state_q != S_GAP);
  end

  // FSM and registered outputs; reset aborts any frame without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      frame_q   <= 11'd0;
      rx_q      <= 8'h00;
      rd_data_q <= 8'h00;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.SS_n    = ss_n_q;
  assign bus.MOSI    = mosi_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_data_q;

`ifdef SPI_RAM_MASTER_ERR_EN
  logic err_q, err_d;
  logic err_sticky_q, err_sticky_d;

  // Flag a start that arrives while busy and is not taken.
  always_comb begin
    err_d        = bus.start && busy_q && !accept;
    err_sticky_d = err_sticky_q || err_d;
  end

  // Error pulse and its sticky copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_spi_ram_master.sv
// Bench for spi_ram_master: behavioural SPI RAM slave, scoreboard of expected
// frames checked on each done pulse, plus directed abort / back-to-back runs.
module tb_spi_ram_master;
  localparam int LEAD = 1, RD_LATENCY = 2, GAP = 1;
  localparam int WR_LEN = LEAD + 11;
  localparam int RD_LEN = LEAD + 11 + RD_LATENCY + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_ram_master_if bus();

  spi_ram_master #(.LEAD(LEAD), .RD_LATENCY(RD_LATENCY), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          len;
    logic [11:0] mosi;
    bit          is_rd;
    logic [7:0]  rd;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural SPI RAM slave.
  logic [7:0]  smem [256];
  logic [7:0]  s_waddr, s_raddr, s_tx;
  logic [11:0] s_bits;
  int          s_n;

  always @(posedge clk) begin
    if (rst || bus.SS_n) begin
      s_n    = 0;
      s_bits = '0;
    end else begin
      s_bits = {s_bits[10:0], bus.MOSI};
      s_n++;
      if (s_n == WR_LEN) begin
        case (s_bits[9:8])
          2'b00: s_waddr = s_bits[7:0];
          2'b01: smem[s_waddr] = s_bits[7:0];
          2'b10: s_raddr = s_bits[7:0];
          default: s_tx = smem[s_raddr];
        endcase
      end
    end
  end

  // Reply byte in the read window; noise on MISO everywhere else.
  always @(negedge clk) begin
    if (!bus.SS_n && s_n >= WR_LEN + RD_LATENCY && s_n < RD_LEN)
      bus.MISO = s_tx[7 - (s_n - WR_LEN - RD_LATENCY)];
    else
      bus.MISO = 1'($urandom_range(0, 1));
  end

  // Frame monitor: length and MOSI bits, scored at each done pulse.
  int          low_cnt = 0;
  logic [11:0] mosi_cap = '0;
  int          done_cnt = 0;
  int          err_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.SS_n) begin
        low_cnt++;
        if (low_cnt <= WR_LEN) mosi_cap = {mosi_cap[10:0], bus.MOSI};
      end else begin
        if (bus.done) begin
          done_cnt++;
          if (exp_q.size() == 0) chk("spurious_done", 1, 0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ss_low_len", low_cnt, e.len);
            chk("mosi_seq", mosi_cap, e.mosi);
            if (e.is_rd) chk("rd_data", bus.rd_data, e.rd);
          end
        end
        low_cnt  = 0;
        mosi_cap = '0;
      end
`ifdef SPI_RAM_MASTER_ERR_EN
      if (bus.err) err_cnt++;
`endif
    end
  end

  function automatic exp_t mk_exp(input logic [1:0] c, input logic [7:0] d, input logic [7:0] erd);
    exp_t e;
    e.is_rd = (c == 2'b11);
    e.len   = e.is_rd ? RD_LEN : WR_LEN;
    e.mosi  = {1'b0, c[1], c[1], c[0], e.is_rd ? 8'hFF : d};
    e.rd    = erd;
    return e;
  endfunction

  // One frame; optional stray start 'poke' busy cycles into it.
  task automatic do_frame(input logic [1:0] c, input logic [7:0] d, input logic [7:0] erd,
                          input int poke);
    int n;
    exp_t e;
    chk("idle_busy", bus.busy, 0);
    e = mk_exp(c, d, erd);
    exp_q.push_back(e);
    bus.start = 1'b1; bus.cmd = c; bus.wr_data = d;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      bus.start = (n == poke);
      if (n == poke) begin bus.cmd = 2'b01; bus.wr_data = 8'h55; end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("busy_len", n, e.len + GAP);
  endtask

  int d0, hi, gaps;
  bit seen_low;

  initial begin
    bus.start = 1'b0; bus.cmd = 2'b00; bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", bus.SS_n, 1);
    chk("rst_mosi", bus.MOSI, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_frame(2'b00, 8'hFF, 8'h00, -1);
    do_frame(2'b01, 8'hAA, 8'h00, -1);
    do_frame(2'b10, 8'hFF, 8'h00, -1);
    do_frame(2'b11, 8'h00, 8'hAA, -1);
    do_frame(2'b00, 8'h12, 8'h00, -1);
    do_frame(2'b01, 8'h3C, 8'h00, -1);
    do_frame(2'b10, 8'h12, 8'h00, -1);
    do_frame(2'b11, 8'h77, 8'h3C, -1);
    do_frame(2'b00, 8'h00, 8'h00, -1);
    chk("rd_hold", bus.rd_data, 8'h3C);
    do_frame(2'b10, 8'hFF, 8'h00, -1);
    do_frame(2'b11, 8'h00, 8'hAA, -1);

    // Stray start mid-frame: no second frame, latched request untouched.
    d0 = done_cnt;
    do_frame(2'b00, 8'hC3, 8'h00, 5);
    repeat (30) @(negedge clk);
    chk("poke_one_done", done_cnt - d0, 1);
    chk("poke_no_restart", bus.busy, 0);
`ifdef SPI_RAM_MASTER_ERR_EN
    chk("err_pulses", err_cnt, 1);
    chk("err_sticky", bus.err_sticky, 1);
`endif

    // start held high: three frames exactly GAP apart.
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk_exp(2'b00, 8'h5A, 8'h00));
    bus.start = 1'b1; bus.cmd = 2'b00; bus.wr_data = 8'h5A;
    hi = 0; gaps = 0; seen_low = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 28) bus.start = 1'b0;
      if (!bus.SS_n) begin
        if (seen_low && hi > 0) begin
          chk("b2b_gap", hi, GAP);
          gaps++;
        end
        seen_low = 1;
        hi = 0;
      end else hi++;
    end
    chk("b2b_gaps", gaps, 2);
    chk("b2b_done", done_cnt - d0, 3);

    // Reset in the middle of the read window of a cmd=11 frame.
    d0 = done_cnt;
    bus.start = 1'b1; bus.cmd = 2'b11; bus.wr_data = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    chk("pre_rst_ss_n", bus.SS_n, 0);
    rst = 1'b1;
    #1;
    chk("abort_ss_n", bus.SS_n, 1);
    chk("abort_mosi", bus.MOSI, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd_data", bus.rd_data, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
